// File: rtl/bsg_gateway_mem_cmd_mux.sv
// Round-robin N-to-1 memory command mux with an in-order tag FIFO.
// The FIFO steers each backend response to the channel that issued the matching command.
module bsg_gateway_mem_cmd_mux #(
  parameter int num_channels_p    = 2,
  parameter int msg_width_p       = 512,
  parameter int max_outstanding_p = 8,
  localparam int lg_channels_lp    = (num_channels_p > 1) ? $clog2(num_channels_p) : 1,
  localparam int lg_outstanding_lp = $clog2(max_outstanding_p + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_channels_p*msg_width_p-1:0] cmd_i,
  input  logic [num_channels_p-1:0]             cmd_v_i,
  output logic [num_channels_p-1:0]             cmd_yumi_o,
  output logic [msg_width_p-1:0]                mem_cmd_o,
  output logic                                  mem_cmd_v_o,
  input  logic                                  mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]                mem_resp_i,
  input  logic                                  mem_resp_v_i,
  output logic                                  mem_resp_yumi_o,
  output logic [msg_width_p-1:0]                resp_o,
  output logic [num_channels_p-1:0]             resp_v_o,
  input  logic [num_channels_p-1:0]             resp_yumi_i,
  output logic [lg_outstanding_lp-1:0]          outstanding_o,
  output logic                                  error_o
);

  localparam int lg_depth_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam logic [lg_channels_lp:0]      num_ch_lp   = (lg_channels_lp+1)'(num_channels_p);
  localparam logic [lg_depth_lp-1:0]       last_idx_lp = lg_depth_lp'(max_outstanding_p - 1);
  localparam logic [lg_outstanding_lp-1:0] full_cnt_lp = lg_outstanding_lp'(max_outstanding_p);

  logic [lg_channels_lp-1:0]    ptr_reg, ptr_next;
  logic [lg_depth_lp-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [lg_depth_lp-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [lg_outstanding_lp-1:0] count_reg, count_next;
  logic                         error_reg, error_next;

  logic [lg_channels_lp-1:0] tag_mem [max_outstanding_p];
  logic [lg_channels_lp-1:0] cand_idx [num_channels_p];
  logic [msg_width_p-1:0]    cmd_arr [num_channels_p];
  logic [lg_channels_lp-1:0] winner;
  logic [lg_channels_lp-1:0] head_tag;
  logic                      any_v, fifo_full, fifo_empty, issue, pop, resp_valid;

  // cand_idx[gi] is the channel holding priority rank gi relative to ptr_reg.
  genvar gi;
  generate
    for (gi = 0; gi < num_channels_p; gi++) begin : g_chan
      logic [lg_channels_lp:0] sum;
      assign sum          = {1'b0, ptr_reg} + (lg_channels_lp+1)'(gi);
      assign cand_idx[gi] = (sum >= num_ch_lp) ? lg_channels_lp'(sum - num_ch_lp)
                                               : lg_channels_lp'(sum);
      assign cmd_arr[gi]  = cmd_i[gi*msg_width_p +: msg_width_p];
      assign cmd_yumi_o[gi] = issue && (winner == lg_channels_lp'(gi));
      assign resp_v_o[gi]   = resp_valid && (head_tag == lg_channels_lp'(gi));
    end
  endgenerate

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    winner = '0;
    for (int i = num_channels_p - 1; i >= 0; i--) begin
      if (cmd_v_i[cand_idx[i]]) winner = cand_idx[i];
    end
  end

  assign any_v       = |cmd_v_i;
  assign fifo_full   = (count_reg == full_cnt_lp);
  assign fifo_empty  = (count_reg == '0);
  assign mem_cmd_v_o = reset_n_i && any_v && !fifo_full;
  assign mem_cmd_o   = any_v ? cmd_arr[winner] : '0;
  assign issue       = mem_cmd_v_o && mem_cmd_ready_i;

  assign head_tag        = tag_mem[rd_ptr_reg];
  assign resp_valid      = mem_resp_v_i && !fifo_empty;
  assign resp_o          = mem_resp_i;
  assign mem_resp_yumi_o = |(resp_yumi_i & resp_v_o);
  assign pop             = mem_resp_yumi_o;

  assign outstanding_o = count_reg;
  assign error_o       = error_reg;

  always_comb begin
    ptr_next    = ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    error_next  = error_reg;
    if (issue) begin
      ptr_next    = (winner == lg_channels_lp'(num_channels_p - 1)) ? '0 : winner + 1'b1;
      wr_ptr_next = (wr_ptr_reg == last_idx_lp) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) rd_ptr_next = (rd_ptr_reg == last_idx_lp) ? '0 : rd_ptr_reg + 1'b1;
    if (issue && !pop) count_next = count_reg + 1'b1;
    else if (pop && !issue) count_next = count_reg - 1'b1;
    // A response with nothing outstanding, or an ack on a channel not being offered one.
    if ((mem_resp_v_i && fifo_empty) || |(resp_yumi_i & ~resp_v_o)) error_next = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      error_reg  <= 1'b0;
    end else begin
      ptr_reg    <= ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      error_reg  <= error_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) tag_mem[wr_ptr_reg] <= winner;
  end

endmodule

// File: tb/tb_bsg_gateway_mem_cmd_mux.sv
// Randomized and directed checks of bsg_gateway_mem_cmd_mux against a queue-based model.
module tb_bsg_gateway_mem_cmd_mux;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int M  = 8;
  localparam int LO = $clog2(M + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] cmd;
  logic [N-1:0]   cmd_v, cmd_yumi, resp_v_out, resp_yumi;
  logic [W-1:0]   mem_cmd, mem_resp, resp_out;
  logic           mem_cmd_v, mem_cmd_ready, mem_resp_v, mem_resp_yumi, error;
  logic [LO-1:0]  outstanding;

  bsg_gateway_mem_cmd_mux #(
    .num_channels_p(N), .msg_width_p(W), .max_outstanding_p(M)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_yumi_o(cmd_yumi),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi),
    .resp_o(resp_out), .resp_v_o(resp_v_out), .resp_yumi_i(resp_yumi),
    .outstanding_o(outstanding), .error_o(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: outstanding channel ids in issue order, priority pointer, sticky error.
  int q[$];
  int ptr_m;
  bit err_m;

  logic [N-1:0] one = 1;
  logic [N-1:0] obs_yumi, obs_resp_v;
  logic         obs_mcv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs set; compares one cycle, advances the model, returns at next negedge.
  task automatic step();
    int w;
    bit any, full, empty, issue, pop, errc, emcv;
    logic [N-1:0] ey, erv;
    logic [W-1:0] ecmd;
    #1;
    full  = (q.size() == M);
    empty = (q.size() == 0);
    any   = |cmd_v;
    w     = 0;
    for (int i = N - 1; i >= 0; i--) if (cmd_v[(ptr_m + i) % N]) w = (ptr_m + i) % N;
    emcv  = any && !full;
    issue = emcv && mem_cmd_ready;
    ey    = issue ? (one << w) : '0;
    ecmd  = any ? cmd[w*W +: W] : '0;
    erv   = (mem_resp_v && !empty) ? (one << q[0]) : '0;
    pop   = (erv != '0) && resp_yumi[q[0]];
    errc  = (mem_resp_v && empty) || ((resp_yumi & ~erv) != '0);
    check("mem_cmd_v", 64'(mem_cmd_v), 64'(emcv));
    check("cmd_yumi", 64'(cmd_yumi), 64'(ey));
    check("mem_cmd", 64'(mem_cmd), 64'(ecmd));
    check("resp_v", 64'(resp_v_out), 64'(erv));
    check("resp_data", 64'(resp_out), 64'(mem_resp));
    check("mem_resp_yumi", 64'(mem_resp_yumi), 64'(pop));
    check("outstanding", 64'(outstanding), 64'(q.size()));
    check("error", 64'(error), 64'(err_m));
    obs_yumi   = cmd_yumi;
    obs_resp_v = resp_v_out;
    obs_mcv    = mem_cmd_v;
    if (issue) $display("t=%0t issue ch%0d cmd=%h outstanding=%0d", $time, w, ecmd, q.size());
    if (pop)   $display("t=%0t resp  ch%0d data=%h", $time, q[0], mem_resp);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (issue) begin
      q.push_back(w);
      ptr_m = (w + 1) % N;
    end
    if (errc) err_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cmd_v = '0; mem_cmd_ready = 1'b1; mem_resp_v = 1'b0; resp_yumi = '0;
    cmd = {$urandom, $urandom, $urandom, $urandom};
    mem_resp = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    q.delete(); ptr_m = 0; err_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ack_head();
    mem_resp_v = (q.size() > 0);
    resp_yumi  = (q.size() > 0) ? (one << q[0]) : '0;
    mem_resp   = $urandom;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #1 rst_n = 1'b0;
    cmd_v = 4'hF; mem_resp_v = 1'b1; resp_yumi = 4'hF;
    #2;
    check("rst_mem_cmd_v", 64'(mem_cmd_v), 64'd0);
    check("rst_cmd_yumi", 64'(cmd_yumi), 64'd0);
    check("rst_resp_v", 64'(resp_v_out), 64'd0);
    check("rst_mem_resp_yumi", 64'(mem_resp_yumi), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    @(negedge clk);
    do_reset();

    // Fairness: every channel requesting, backend ready, head acked each cycle.
    for (int k = 0; k < 12; k++) begin
      cmd_v = 4'hF; cmd = {$urandom, $urandom, $urandom, $urandom};
      ack_head();
      step();
      check("fair_grant", 64'(obs_yumi), 64'(one << (k % 4)));
    end

    // Responses follow issue order, not channel order.
    do_reset();
    cmd_v = 4'b0100; step();
    cmd_v = 4'b0001; step();
    cmd_v = 4'b0100; step();
    cmd_v = '0;
    ack_head(); step(); check("route_0", 64'(obs_resp_v), 64'b0100);
    ack_head(); step(); check("route_1", 64'(obs_resp_v), 64'b0001);
    ack_head(); step(); check("route_2", 64'(obs_resp_v), 64'b0100);
    mem_resp_v = 1'b0; resp_yumi = '0;

    // Fill to the limit, then confirm the one-cycle stall after a pop.
    do_reset();
    cmd_v = 4'hF;
    for (int k = 0; k < M; k++) step();
    for (int k = 0; k < 2; k++) begin
      step();
      check("full_stall", 64'(obs_mcv), 64'd0);
      check("full_count", 64'(outstanding), 64'(M));
    end
    ack_head(); step();
    check("full_pop_stall", 64'(obs_mcv), 64'd0);
    mem_resp_v = 1'b0; resp_yumi = '0;
    step();
    check("full_resume", 64'(obs_mcv), 64'd1);

    // Backpressure freezes the pointer.
    do_reset();
    cmd_v = 4'b0011; mem_cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_no_yumi", 64'(obs_yumi), 64'd0);
    end
    mem_cmd_ready = 1'b1; step();
    check("bp_first", 64'(obs_yumi), 64'b0001);

    // Response with nothing outstanding.
    do_reset();
    mem_resp_v = 1'b1; step();
    mem_resp_v = 1'b0;
    check("err_set", 64'(error), 64'd1);
    step();

    // Asynchronous reset in the middle of a burst.
    cmd_v = 4'hF;
    for (int k = 0; k < 3; k++) step();
    check("burst_count", 64'(outstanding), 64'd3);
    #2 rst_n = 1'b0; mem_resp_v = 1'b1; resp_yumi = 4'hF;
    #1;
    check("arst_mem_cmd_v", 64'(mem_cmd_v), 64'd0);
    check("arst_cmd_yumi", 64'(cmd_yumi), 64'd0);
    check("arst_resp_v", 64'(resp_v_out), 64'd0);
    check("arst_outstanding", 64'(outstanding), 64'd0);
    check("arst_error", 64'(error), 64'd0);
    @(negedge clk);
    do_reset();

    // Random traffic with a well-behaved backend.
    for (int k = 0; k < 400; k++) begin
      cmd_v = N'($urandom);
      cmd = {$urandom, $urandom, $urandom, $urandom};
      mem_cmd_ready = ($urandom_range(0, 3) != 0);
      mem_resp_v = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      resp_yumi = (mem_resp_v && $urandom_range(0, 2) != 0) ? (one << q[0]) : '0;
      mem_resp = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
